// File: rtl/cod_8_3_rr.sv
// Sticky 8-source request collector with a round-robin (or fixed-priority)
// 8-to-3 index encoder, presenting one pending source at a time over valid/ready.
module cod_8_3_rr #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [2:0] sel_out,
    output logic [7:0] onehot_out,
    output logic [7:0] pending_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] onehot_q, onehot_d;
    logic [7:0] pending_q, pending_d;
    logic       valid_q, valid_d;

    logic       accept_s;
    logic [7:0] clr_mask_s;
    logic [2:0] ptr_eff_s;
    logic [2:0] ptr_after_s;
    logic [3:0] pick_idle_s;
    logic [3:0] pick_next_s;

    // Search starting at ptr and wrapping; returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] cand, input logic [2:0] ptr);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {cand, cand} >> ptr;
        rot = dbl[7:0];
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end else begin
                off = off;
            end
        end
        return {(cand != 8'h00), 3'(ptr + off)};
    endfunction

    function automatic logic [7:0] onehot_of(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    assign accept_s    = valid_q & ready_in;
    assign clr_mask_s  = accept_s ? onehot_q : 8'h00;
    assign ptr_eff_s   = ROUND_ROBIN ? ptr_q : 3'd0;
    assign ptr_after_s = ROUND_ROBIN ? 3'(sel_q + 3'd1) : 3'd0;
    // Back-to-back candidate deliberately ignores this cycle's req_in.
    assign pick_idle_s = rr_pick(pending_q, ptr_eff_s);
    assign pick_next_s = rr_pick(pending_q & ~onehot_q, ptr_after_s);

    // Pending update: a same-cycle set beats the accept clear.
    always_comb begin
        pending_d = (pending_q & ~clr_mask_s) | req_in;
    end

    // Offer FSM: choose, hold under backpressure, advance on accept.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s[3]) begin
                    state_d  = ST_OFFER;
                    sel_d    = pick_idle_s[2:0];
                    valid_d  = 1'b1;
                    onehot_d = onehot_of(pick_idle_s[2:0]);
                end else begin
                    valid_d  = 1'b0;
                    onehot_d = 8'h00;
                end
            end
            ST_OFFER: begin
                if (accept_s) begin
                    ptr_d = ptr_after_s;
                    if (pick_next_s[3]) begin
                        sel_d    = pick_next_s[2:0];
                        valid_d  = 1'b1;
                        onehot_d = onehot_of(pick_next_s[2:0]);
                    end else begin
                        state_d  = ST_IDLE;
                        valid_d  = 1'b0;
                        onehot_d = 8'h00;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b0;
                onehot_d = 8'h00;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            sel_q     <= 3'd0;
            valid_q   <= 1'b0;
            onehot_q  <= 8'h00;
            pending_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            pending_q <= pending_d;
        end
    end

    assign valid_out   = valid_q;
    assign sel_out     = sel_q;
    assign onehot_out  = onehot_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_cod_8_3_rr.sv
// Bench for cod_8_3_rr: a round-robin and a fixed-priority instance against
// an abstract queue-style model, plus hand-computed directed expectations.
module tb_cod_8_3_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ready = 1'b0;

    logic       v1, v0;
    logic [2:0] s1, s0;
    logic [7:0] o1, o0, p1, p0;

    int checks = 0;
    int errors = 0;

    // model state, index 1 = rotating priority, index 0 = fixed priority
    bit         mv[2];
    int         ms[2];
    int         mptr[2];
    logic [7:0] mp[2];

    always #5 clk = ~clk;

    cod_8_3_rr #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req), .ready_in(ready),
        .valid_out(v1), .sel_out(s1), .onehot_out(o1), .pending_out(p1));

    cod_8_3_rr #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_in(req), .ready_in(ready),
        .valid_out(v0), .sel_out(s0), .onehot_out(o0), .pending_out(p0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [7:0] vec, input int start);
        for (int k = 0; k < 8; k++) begin
            if (vec[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        bit         nv;
        int         ns, nptr, n;
        logic [7:0] granted, one, np;
        bit         acc;
        one     = 8'h01;
        nv      = mv[m];
        ns      = ms[m];
        nptr    = mptr[m];
        acc     = mv[m] && ready;
        granted = mv[m] ? (one << ms[m]) : 8'h00;
        np      = (mp[m] & ~(acc ? granted : 8'h00)) | req;
        if (!mv[m]) begin
            n = first_from(mp[m], (m == 1) ? mptr[m] : 0);
            if (n >= 0) begin
                nv = 1'b1;
                ns = n;
            end
        end else if (acc) begin
            nptr = (m == 1) ? (ms[m] + 1) % 8 : 0;
            n = first_from(mp[m] & ~granted, nptr);
            if (n >= 0) ns = n;
            else nv = 1'b0;
        end
        mv[m]   <= nv;
        ms[m]   <= ns;
        mptr[m] <= nptr;
        mp[m]   <= np;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mv[m] <= 1'b0; ms[m] <= 0; mptr[m] <= 0; mp[m] <= 8'h00;
            end
        end else begin
            model_step(1);
            model_step(0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] one;
        one = 8'h01;
        if (rst_n) begin
            check("rr_valid", {31'd0, v1}, {31'd0, mv[1]});
            check("rr_onehot", {24'd0, o1}, mv[1] ? {24'd0, one << ms[1]} : 32'd0);
            check("rr_pending", {24'd0, p1}, {24'd0, mp[1]});
            if (mv[1]) check("rr_sel", {29'd0, s1}, ms[1]);
            check("fp_valid", {31'd0, v0}, {31'd0, mv[0]});
            check("fp_onehot", {24'd0, o0}, mv[0] ? {24'd0, one << ms[0]} : 32'd0);
            check("fp_pending", {24'd0, p0}, {24'd0, mp[0]});
            if (mv[0]) check("fp_sel", {29'd0, s0}, ms[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic expect_offer(input string name, input logic [2:0] sel);
        logic [7:0] one;
        one = 8'h01;
        check({name, "_valid"}, {31'd0, v1}, 32'd1);
        check({name, "_sel"}, {29'd0, s1}, {29'd0, sel});
        check({name, "_onehot"}, {24'd0, o1}, {24'd0, one << sel});
    endtask

    task automatic expect_idle(input string name, input logic [7:0] pend);
        check({name, "_valid"}, {31'd0, v1}, 32'd0);
        check({name, "_onehot"}, {24'd0, o1}, 32'd0);
        check({name, "_pending"}, {24'd0, p1}, {24'd0, pend});
    endtask

    task automatic expect_fp(input string name, input logic [2:0] sel);
        check({name, "_valid"}, {31'd0, v0}, 32'd1);
        check({name, "_sel"}, {29'd0, s0}, {29'd0, sel});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();
        expect_idle("reset", 8'h00);
        check("reset_sel", {29'd0, s1}, 32'd0);

        // single request with a long stall
        req = 8'h10; cyc(); req = 8'h00;
        expect_idle("t1_pend", 8'h10);
        cyc(); expect_offer("t1_offer", 3'd4);
        cyc(); expect_offer("t1_hold_a", 3'd4);
        cyc(); expect_offer("t1_hold_b", 3'd4);
        ready = 1'b1;
        cyc(); expect_idle("t1_done", 8'h00);
        req = 8'h21; cyc(); req = 8'h00;
        cyc(); expect_offer("t1_ptr5", 3'd5);
        cyc(); expect_offer("t1_after5", 3'd0);
        cyc(); expect_idle("t1_end", 8'h00);

        // full burst
        do_reset();
        ready = 1'b1;
        req = 8'hFF; cyc(); req = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cyc(); expect_offer("t2_burst", 3'(i));
        end
        cyc(); expect_idle("t2_end", 8'h00);

        // wrap-around
        do_reset();
        ready = 1'b1;
        req = 8'h20; cyc(); req = 8'h00;
        cyc(); expect_offer("t3_five", 3'd5);
        cyc();
        req = 8'h41; cyc(); req = 8'h00;
        cyc(); expect_offer("t3_six", 3'd6);
        cyc(); expect_offer("t3_zero", 3'd0);
        cyc();
        req = 8'h81; cyc(); req = 8'h00;
        cyc(); expect_offer("t3_ptr1_seven", 3'd7);
        cyc(); expect_offer("t3_ptr1_zero", 3'd0);
        cyc(); expect_idle("t3_end", 8'h00);

        // backpressure with a new request during the stall
        do_reset();
        req = 8'h0C; cyc(); req = 8'h00;
        cyc(); expect_offer("t4_first", 3'd2);
        for (int i = 0; i < 5; i++) begin
            req = (i == 1) ? 8'h01 : 8'h00;
            cyc(); expect_offer("t4_stall", 3'd2);
        end
        req = 8'h00;
        check("t4_pend", {24'd0, p1}, 32'h0D);
        ready = 1'b1;
        cyc(); expect_offer("t4_g3", 3'd3);
        cyc(); expect_offer("t4_g0", 3'd0);
        cyc(); expect_idle("t4_end", 8'h00);

        // set/clear collision
        do_reset();
        ready = 1'b1;
        req = 8'h05; cyc(); req = 8'h00;
        cyc(); expect_offer("t5_g0", 3'd0);
        cyc(); expect_offer("t5_g2", 3'd2);
        req = 8'h04;
        cyc(); req = 8'h00;
        expect_idle("t5_collide", 8'h04);
        cyc(); expect_offer("t5_again", 3'd2);
        cyc(); expect_idle("t5_end", 8'h00);

        // asynchronous reset mid-offer, then fixed-priority behaviour
        do_reset();
        req = 8'h81; cyc(); req = 8'h00;
        cyc(); expect_offer("t6_pre", 3'd0);
        #1 rst_n = 1'b0;
        #1;
        expect_idle("t6_async", 8'h00);
        check("t6_async_sel", {29'd0, s1}, 32'd0);
        check("t6_fp_valid", {31'd0, v0}, 32'd0);
        check("t6_fp_pend", {24'd0, p0}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ready = 1'b1;
        req = 8'h81; cyc(); req = 8'h00;
        cyc(); expect_fp("t6_fp_a0", 3'd0);
        cyc(); expect_fp("t6_fp_a7", 3'd7);
        req = 8'h81; cyc(); req = 8'h00;
        check("t6_fp_idle", {31'd0, v0}, 32'd0);
        cyc(); expect_fp("t6_fp_b0", 3'd0);
        cyc(); expect_fp("t6_fp_b7", 3'd7);
        cyc();
        check("t6_fp_end", {31'd0, v0}, 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
